// File: rtl/mat_pkg.sv
// Shared types and constants for the 8x8 matrix scan controller.
// Holds the scan FSM state enum, matrix geometry and a one-hot row helper.
package mat_pkg;

  localparam int unsigned MAT_ROWS = 8;
  localparam int unsigned MAT_COLS = 8;
  localparam int unsigned ROW_W    = $clog2(MAT_ROWS);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } mat_state_e;

  // One-hot row select for a row index.
  function automatic logic [MAT_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    return MAT_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/mat_timer.sv
// Dwell/blank down-counter for the scan FSM.
// Ports:
//   clk, rst     - clock, async active-high reset
//   load         - reload strobe (asserted on every FSM state entry)
//   load_val     - period length minus one
//   done         - registered: current cycle is the last of the period
//   done_next_c  - combinational: next cycle will be the last of the period
module mat_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic         done_next_c
);

  logic [W-1:0] cnt;

  // Counter reaches zero on the next edge: freshly loaded with 0, or at 1/0 now.
  assign done_next_c = load ? (load_val == '0) : (cnt <= W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b1;
    end else begin
      if (load)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - W'(1);
      done <= done_next_c;
    end
  end

endmodule

// File: rtl/mat_scan_ctrl.sv
// Double-buffered 8x8 LED matrix row-scan controller.
// Ports:
//   clk, rst              - clock, async active-high reset
//   en                    - scan enable (0 = display off)
//   wr_valid/wr_ready     - back-buffer row write handshake
//   wr_row, wr_data       - row index and column pattern to write
//   swap_req/swap_ack     - front/back buffer exchange request and pulse
//   row, col              - one-hot row select and column drive
//   frame_done            - pulse on the last drive cycle of row 7
module mat_scan_ctrl
  import mat_pkg::*;
#(
  parameter int unsigned DWELL = 10,
  parameter int unsigned BLANK = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ROW_W-1:0]    wr_row,
  input  logic [MAT_COLS-1:0] wr_data,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic [MAT_ROWS-1:0] row,
  output logic [MAT_COLS-1:0] col,
  output logic                frame_done
);

  localparam int unsigned SPAN = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = $clog2(SPAN + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam bit NO_BLANK = (BLANK == 0);

  mat_state_e          state;
  logic [ROW_W-1:0]    idx;
  logic                sel;
  logic                pending;
  logic [MAT_COLS-1:0] bank [2][MAT_ROWS];

  logic             done, done_next;
  logic             load;
  logic [CW-1:0]    load_val;
  logic             drive_end, blank_end, enter_drive, enter_blank, stay_drive;
  logic             drive_next, last_next, ack_next, pend_next;
  logic [ROW_W-1:0] idx_next;

  // Transition decode; row/col/frame_done/swap_ack are registered from these.
  always_comb begin
    drive_end   = (state == ST_DRIVE) && done;
    blank_end   = (state == ST_BLANK) && done;
    enter_drive = en && (((state == ST_OFF) && NO_BLANK) || blank_end || (drive_end && NO_BLANK));
    enter_blank = en && (((state == ST_OFF) && !NO_BLANK) || (drive_end && !NO_BLANK));
    stay_drive  = en && (state == ST_DRIVE) && !done;
    drive_next  = enter_drive || stay_drive;
    // Reload on every state entry, including the drop to OFF.
    load        = (state == ST_OFF) ? en : (!en || done);
    load_val    = enter_drive ? DWELL_LD : (enter_blank ? BLANK_LD : '0);
    idx_next    = !en ? '0 : (drive_end ? idx + ROW_W'(1) : idx);
    last_next   = drive_next && done_next && (idx_next == ROW_W'(MAT_ROWS - 1));
    // Pending stays set through the ack cycle; a request seen then is dropped.
    pend_next   = !swap_ack && (pending || swap_req);
    ack_next    = pend_next && (!en || last_next);
  end

  mat_timer #(.W(CW)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .done        (done),
    .done_next_c (done_next)
  );

  // Scan FSM, buffers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OFF;
      idx        <= '0;
      sel        <= 1'b0;
      pending    <= 1'b0;
      wr_ready   <= 1'b1;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
      row        <= '0;
      col        <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < int'(MAT_ROWS); r++)
          bank[b][r] <= '0;
    end else begin
      if (!en)
        state <= ST_OFF;
      else if (enter_drive)
        state <= ST_DRIVE;
      else if (enter_blank)
        state <= ST_BLANK;

      idx <= idx_next;
      row <= drive_next ? row_onehot(idx_next) : '0;

      // Column pattern is latched once per row so a mid-row swap is invisible.
      if (enter_drive)
        col <= bank[sel][idx_next];
      else if (!stay_drive)
        col <= '0;

      // Writes target the pre-swap back bank even when the swap fires this edge.
      if (wr_valid && wr_ready)
        bank[!sel][wr_row] <= wr_data;

      pending    <= pend_next;
      wr_ready   <= !pend_next;
      swap_ack   <= ack_next;
      frame_done <= last_next;
      if (ack_next)
        sel <= !sel;
    end
  end

endmodule

// File: tb/tb_mat_scan_ctrl.sv
// Bench for mat_scan_ctrl: two instances (DWELL=10/BLANK=2 and DWELL=1/BLANK=0)
// share stimulus and are compared each cycle against a frame-position model.
module tb_mat_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, wr_valid, swap_req;
  logic [2:0] wr_row;
  logic [7:0] wr_data;

  logic       wr_ready [2];
  logic       swap_ack [2];
  logic       frame_done [2];
  logic [7:0] row_o [2];
  logic [7:0] col_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mat_scan_ctrl #(.DWELL(10), .BLANK(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready[0]),
    .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack[0]),
    .row(row_o[0]), .col(col_o[0]), .frame_done(frame_done[0])
  );

  mat_scan_ctrl #(.DWELL(1), .BLANK(0)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready[1]),
    .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack[1]),
    .row(row_o[1]), .col(col_o[1]), .frame_done(frame_done[1])
  );

  // Reference model: position within the frame, pattern latched per row.
  int         m_on [2];
  int         m_pos [2];
  int         m_pend [2];
  int         m_ack [2];
  int         m_sel [2];
  int         m_fd [2];
  logic [7:0] m_col [2];
  logic [7:0] m_mem [2][2][8];

  function automatic int dwell_of(input int i);
    return (i == 0) ? 10 : 1;
  endfunction

  function automatic int blank_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_pos[i] = 0; m_pend[i] = 0; m_ack[i] = 0;
      m_sel[i] = 0; m_fd[i] = 0; m_col[i] = 8'h00;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          m_mem[i][b][r] = 8'h00;
    end
  endtask

  // Advance the model one clock edge using the inputs held before the edge.
  task automatic m_edge();
    for (int i = 0; i < 2; i++) begin
      int len, per, pos_n, on_n, last_n, ack_n, pend_n;
      len = dwell_of(i) + blank_of(i);
      per = 8 * len;
      if (!en) begin on_n = 0; pos_n = 0; end
      else if (m_on[i] == 0) begin on_n = 1; pos_n = 0; end
      else begin on_n = 1; pos_n = (m_pos[i] + 1) % per; end
      last_n = (on_n != 0 && pos_n == per - 1) ? 1 : 0;
      pend_n = (m_ack[i] == 0 && (m_pend[i] != 0 || swap_req)) ? 1 : 0;
      ack_n  = (pend_n != 0 && (!en || last_n != 0)) ? 1 : 0;
      if (wr_valid && m_pend[i] == 0)
        m_mem[i][1 - m_sel[i]][wr_row] = wr_data;
      if (on_n != 0 && (pos_n % len) == blank_of(i))
        m_col[i] = m_mem[i][m_sel[i]][pos_n / len];
      if (ack_n != 0) m_sel[i] = 1 - m_sel[i];
      m_on[i] = on_n; m_pos[i] = pos_n; m_pend[i] = pend_n;
      m_ack[i] = ack_n; m_fd[i] = last_n;
    end
  endtask

  function automatic logic m_lit(input int i);
    int len;
    len = dwell_of(i) + blank_of(i);
    return (m_on[i] != 0) && ((m_pos[i] % len) >= blank_of(i));
  endfunction

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int len;
      logic [7:0] er, ec;
      len = dwell_of(i) + blank_of(i);
      er = m_lit(i) ? 8'(1 << (m_pos[i] / len)) : 8'h00;
      ec = m_lit(i) ? m_col[i] : 8'h00;
      chk($sformatf("row[%0d]", i), row_o[i], er);
      chk($sformatf("col[%0d]", i), col_o[i], ec);
      chk($sformatf("frame_done[%0d]", i), frame_done[i], m_fd[i]);
      chk($sformatf("swap_ack[%0d]", i), swap_ack[i], m_ack[i]);
      chk($sformatf("wr_ready[%0d]", i), wr_ready[i], (m_pend[i] == 0) ? 1 : 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset(); else m_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    swap_req = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int found;
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
    wr_row = 3'd0; wr_data = 8'h00;
    m_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_row", row_o[i], 8'h00);
      chk("rst_col", col_o[i], 8'h00);
      chk("rst_ready", wr_ready[i], 1'b1);
      chk("rst_ack", swap_ack[i], 1'b0);
      chk("rst_fd", frame_done[i], 1'b0);
    end
    cycle();
    rst = 1'b0;

    // Blank frames with zeroed banks.
    en = 1'b1;
    idle(200);

    // Fill back buffer with A5 then swap at frame end.
    for (int r = 0; r < 8; r++) begin
      wr_valid = 1'b1; wr_row = 3'(r); wr_data = 8'hA5;
      cycle();
    end
    wr_valid = 1'b0;
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    idle(200);

    // Swap and write together while disabled.
    en = 1'b0;
    idle(2);
    swap_req = 1'b1; wr_valid = 1'b1; wr_row = 3'd3; wr_data = 8'h3C;
    cycle();
    idle(3);
    en = 1'b1;
    idle(200);

    // Drop enable while row 5 is driven on instance A.
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (m_lit(0) && (m_pos[0] / 12) == 5) found = 1;
      else idle(1);
    end
    chk("wait_row5", found, 1);
    en = 1'b0;
    cycle();
    en = 1'b1;
    idle(150);

    // Asynchronous reset while driving.
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (m_lit(0) && m_lit(1)) found = 1;
      else idle(1);
    end
    chk("wait_drive", found, 1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_row", row_o[i], 8'h00);
      chk("async_col", col_o[i], 8'h00);
      chk("async_ready", wr_ready[i], 1'b1);
    end
    m_reset();
    idle(1);
    rst = 1'b0;
    idle(100);
    swap_req = 1'b1;
    cycle();
    idle(200);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      en       = ($urandom_range(0, 399) != 0);
      wr_valid = $urandom_range(0, 1) != 0;
      wr_row   = 3'($urandom);
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(0, 40) == 0);
      cycle();
    end
    idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_scan_ctrl.md
MAT_SCAN_CTRL -- requirements
Module: mat_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 10: clk cycles each row is driven; legal range >=1.
REQ-002 Parameter BLANK, default 2: clk cycles with all outputs off before each row; legal range >=0.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  scan enable; 0 = display off.
REQ-006 wr_valid  input  1  requester offers a back-buffer row write.
REQ-007 wr_ready  output  1  controller accepts a write this cycle.
REQ-008 wr_row  input  3  back-buffer row index 0..7.
REQ-009 wr_data  input  8  column pattern for wr_row; bit n = column n lit.
REQ-010 swap_req  input  1  one-cycle request to exchange front and back buffers.
REQ-011 swap_ack  output  1  one-cycle pulse when the swap executes.
REQ-012 row  output  8  one-hot row select; all-zero when blanked.
REQ-013 col  output  8  column drive for the selected row; all-zero when blanked.
REQ-014 frame_done  output  1  one-cycle pulse on the last DRIVE cycle of row 7.

Function
REQ-015 The block SHALL hold two 8x8-bit banks: front (displayed) and back (written); a bank-select bit chooses front.
REQ-016 A write SHALL be accepted when wr_valid && wr_ready; back[wr_row] <= wr_data on that edge.
REQ-017 wr_ready SHALL be 1 except while a swap is pending (from the cycle after swap_req is sampled through the swap_ack cycle inclusive).
REQ-018 swap_req SHALL set a pending flag; further swap_req while pending SHALL be ignored (no second swap).
REQ-019 A pending swap SHALL execute on the last DRIVE cycle of row 7 when en=1, or on the cycle after swap_req is sampled when en=0.
REQ-020 On execution: bank-select toggles, swap_ack=1 for that cycle, pending clears; no data copy, so the new back holds the old front.
REQ-021 A write and swap_req in the same cycle SHALL both be accepted; the write lands in the pre-swap back bank.
REQ-022 The FSM SHALL have states OFF, BLANK and DRIVE.
REQ-023 In OFF: row=0, col=0, row index=0. en=1 moves to BLANK (or DRIVE if BLANK=0) on the next edge.
REQ-024 In BLANK: row=0, col=0 for exactly BLANK cycles, then DRIVE.
REQ-025 In DRIVE: row=one-hot(idx), col=front[idx] for exactly DWELL cycles, then idx increments mod 8 (7 wraps to 0) and the FSM enters BLANK (or DRIVE if BLANK=0).
REQ-026 col SHALL sample front at the start of each DRIVE period; a swap mid-row does not change col until the next row.
REQ-027 en=0 in any state SHALL force OFF on the next edge, with idx cleared; outputs are 0 from that edge.
REQ-028 The dwell/blank counter SHALL be $clog2(max(DWELL,BLANK)+1) bits wide and SHALL reload on every state entry.
REQ-029 Full frame period SHALL be 8*(DWELL+BLANK) cycles.

Reset
REQ-030 On rst=1, asynchronously: state OFF, idx=0, both banks all-zero, bank-select=0, pending=0, row=0, col=0, swap_ack=0, frame_done=0, wr_ready=1.
REQ-031 rst asserted mid-row SHALL blank row/col immediately, without waiting for a clk edge.

Structure
REQ-032 A shared package mat_pkg SHALL hold the state enum (OFF/BLANK/DRIVE) and constants MAT_ROWS=8, MAT_COLS=8.
REQ-033 The dwell/blank down-counter SHALL be a sub-module mat_timer (load value, load strobe, done flag).

Verification
REQ-034 Reset, en=1, DWELL=10, BLANK=2, banks zero -> row sequence 01,02,...,80,01 with 12-cycle spacing; col=00; frame_done every 96 cycles.
REQ-035 Write rows 0..7 = 8'hA5, swap_req -> swap_ack coincides with the frame_done cycle; the next frame shows col=A5 on every row; wr_ready is 0 from the cycle after swap_req through swap_ack.
REQ-036 en=0 with swap_req and write (row 3, 8'h3C) in the same cycle -> swap_ack the next cycle; after en=1, row 3 (row=08) shows col=3C.
REQ-037 en dropped during DRIVE of row 5 -> row=0 and col=0 on the next edge; after en reasserts, scanning restarts at row=01 after BLANK cycles.
REQ-038 rst pulsed mid-DRIVE -> row and col go to 0 without a clk edge; after release both banks read 0 and wr_ready=1.
REQ-039 BLANK=0, DWELL=1 -> row changes every cycle 01..80 and wraps to 01, with no all-zero gap.
